fp8_normalizer: RTL and testbench



---
 rtl/fp8_normalizer.sv | 129 ++++++++++++
 tb/tb_fp8_normalizer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fp8_normalizer.sv
// Post-add normalizer: two-stage pipeline that finds the leading one and
// left-justifies the mantissa, clamping the exponent at the subnormal boundary.

// Leading-zero count of an 8-bit value; 0x00 and 0x01 both report 7.
module leading_one_detector_8 (
  input  logic [7:0] mant,
  output logic [2:0] n
);

  // Scan from LSB upward so the highest set bit wins
  always_comb begin
    n = 3'd7;
    for (int i = 0; i < 8; i++) begin
      if (mant[i]) n = 3'(7 - i);
    end
  end

endmodule

module fp8_normalizer #(
  parameter int unsigned EXP_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [7:0]       in_mant,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [7:0]       out_mant,
  output logic             out_zero,
  output logic             out_subnormal
);

  localparam int unsigned MANT_W = 8;
  localparam int unsigned LZ_W   = 3;

  logic              v1;
  logic              s1_sign;
  logic [EXP_W-1:0]  s1_exp;
  logic [MANT_W-1:0] s1_mant;
  logic              s1_zero;
  logic [LZ_W-1:0]   s1_lz;

  logic [LZ_W-1:0]   lz_c;
  logic              en1;
  logic              en2;

  logic [EXP_W-1:0]  nx_exp;
  logic [MANT_W-1:0] nx_mant;
  logic              nx_zero;
  logic              nx_subnormal;
  logic [LZ_W-1:0]   sub_shift;

  leading_one_detector_8 u_lod (
    .mant (in_mant),
    .n    (lz_c)
  );

  // Stage enables: a stage advances when it is empty or its successor advances
  always_comb begin
    en2      = ~out_valid | out_ready;
    en1      = ~v1 | en2;
    in_ready = en1;
  end

  // Stage 1: capture operands and leading-zero count
  always_ff @(posedge clk) begin
    if (rst) begin
      v1      <= 1'b0;
      s1_sign <= 1'b0;
      s1_exp  <= '0;
      s1_mant <= '0;
      s1_zero <= 1'b0;
      s1_lz   <= '0;
    end else if (en1) begin
      v1      <= in_valid;
      s1_sign <= in_sign;
      s1_exp  <= in_exp;
      s1_mant <= in_mant;
      s1_zero <= (in_mant == '0);
      s1_lz   <= lz_c;
    end
  end

  // Stage 2 datapath: full normalize if exponent allows, else clamp to subnormal
  always_comb begin
    nx_exp       = '0;
    nx_mant      = '0;
    nx_zero      = 1'b0;
    nx_subnormal = 1'b0;
    sub_shift    = '0;
    if (s1_zero) begin
      nx_zero = 1'b1;
    end else if (s1_exp > EXP_W'(s1_lz)) begin
      nx_mant = s1_mant << s1_lz;
      nx_exp  = s1_exp - EXP_W'(s1_lz);
    end else begin
      // exp <= lz here, so exp-1 always fits in the shift width
      sub_shift    = (s1_exp == '0) ? '0 : LZ_W'(s1_exp - EXP_W'(1));
      nx_mant      = s1_mant << sub_shift;
      nx_subnormal = 1'b1;
    end
  end

  // Stage 2 registers drive the outputs directly
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_sign      <= 1'b0;
      out_exp       <= '0;
      out_mant      <= '0;
      out_zero      <= 1'b0;
      out_subnormal <= 1'b0;
    end else if (en2) begin
      out_valid     <= v1;
      out_sign      <= s1_sign;
      out_exp       <= nx_exp;
      out_mant      <= nx_mant;
      out_zero      <= nx_zero;
      out_subnormal <= nx_subnormal;
    end
  end

endmodule

// File: tb/tb_fp8_normalizer.sv
// Scoreboard bench for fp8_normalizer: directed cases, backpressured stream, mid-stream reset.
module tb_fp8_normalizer;

  localparam int unsigned EW = 5;
  localparam int unsigned RW = EW + 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_sign;
  logic [EW-1:0] in_exp;
  logic [7:0]    in_mant;
  logic          out_valid;
  logic          out_ready;
  logic          out_sign;
  logic [EW-1:0] out_exp;
  logic [7:0]    out_mant;
  logic          out_zero;
  logic          out_subnormal;

  int total = 0;
  int bad   = 0;
  logic [RW-1:0] q[$];
  logic          stall;
  logic [RW-1:0] held;
  logic          acc;
  int            sent;

  fp8_normalizer #(.EXP_W(EW)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_mant       (in_mant),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sign      (out_sign),
    .out_exp       (out_exp),
    .out_mant      (out_mant),
    .out_zero      (out_zero),
    .out_subnormal (out_subnormal)
  );

  always #5 clk = ~clk;

  // Result packing: {sign, exp, mant, zero, subnormal}
  function automatic logic [RW-1:0] model(logic s, logic [EW-1:0] e, logic [7:0] m);
    int lz;
    int sh;
    if (m == 8'h00) return {s, EW'(0), 8'h00, 1'b1, 1'b0};
    lz = 0;
    while (!m[7-lz]) lz++;
    if (int'(e) > lz) return {s, EW'(int'(e) - lz), 8'(m << lz), 1'b0, 1'b0};
    sh = (e == '0) ? 0 : int'(e) - 1;
    return {s, EW'(0), 8'(m << sh), 1'b0, 1'b1};
  endfunction

  function automatic logic [RW-1:0] dut_out();
    return {out_sign, out_exp, out_mant, out_zero, out_subnormal};
  endfunction

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic expect_now(input string tag, input logic [RW-1:0] expv);
    check({tag, "_valid"}, RW'(out_valid), RW'(1));
    check(tag, dut_out(), expv);
  endtask

  // One clock: score handshakes before the edge, check hold behaviour after it
  task automatic tick();
    #1;
    acc   = 1'b0;
    stall = 1'b0;
    if (!rst) begin
      check("in_ready", RW'(in_ready), RW'(!(q.size() == 2 && !out_ready)));
      if (out_valid && out_ready) begin
        check("out_avail", RW'(q.size() != 0), RW'(1));
        if (q.size() != 0) check("data", dut_out(), q.pop_front());
      end
      if (in_valid && in_ready) begin
        q.push_back(model(in_sign, in_exp, in_mant));
        acc = 1'b1;
      end
      stall = out_valid && !out_ready;
      held  = dut_out();
    end else begin
      q.delete();
    end
    @(posedge clk);
    #1;
    if (stall) begin
      check("hold_valid", RW'(out_valid), RW'(1));
      check("hold_data", dut_out(), held);
    end
    @(negedge clk);
  endtask

  task automatic send(input logic s, input logic [EW-1:0] e, input logic [7:0] m);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 10 && q.size() != 0; i++) tick();
    check("drain_empty", RW'(q.size()), RW'(0));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    out_ready = 1'b1;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    check("rst_valid", RW'(out_valid), RW'(0));
    check("rst_data", dut_out(), RW'(0));
    check("rst_in_ready", RW'(in_ready), RW'(1));

    // Basic normalize, with latency: valid appears after the second edge
    send(1'b1, EW'(10), 8'h10);
    check("lat1_s1", RW'(out_valid), RW'(0));
    tick();
    expect_now("basic", {1'b1, EW'(7), 8'h80, 1'b0, 1'b0});
    drain();

    // Zero vs 0x01 share lz=7
    send(1'b0, EW'(9), 8'h00);
    in_valid = 1'b1; in_sign = 1'b0; in_exp = EW'(9); in_mant = 8'h01;
    tick();
    in_valid = 1'b0;
    expect_now("zero", {1'b0, EW'(0), 8'h00, 1'b1, 1'b0});
    tick();
    expect_now("one", {1'b0, EW'(2), 8'h80, 1'b0, 1'b0});
    drain();

    // Subnormal clamp and the exp == lz+1 boundary
    send(1'b0, EW'(3), 8'h04);
    tick();
    expect_now("sub_e3", {1'b0, EW'(0), 8'h10, 1'b0, 1'b1});
    drain();
    send(1'b1, EW'(0), 8'h04);
    tick();
    expect_now("sub_e0", {1'b1, EW'(0), 8'h04, 1'b0, 1'b1});
    drain();
    send(1'b0, EW'(6), 8'h04);
    tick();
    expect_now("bound_e6", {1'b0, EW'(1), 8'h80, 1'b0, 1'b0});
    drain();

    // Random stream under random backpressure
    sent     = 0;
    in_valid = 1'b1;
    in_sign  = 1'($urandom);
    in_exp   = EW'($urandom);
    in_mant  = 8'($urandom);
    for (int cyc = 0; cyc < 300 && sent < 20; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
      if (acc) begin
        sent++;
        in_sign = 1'($urandom);
        in_exp  = EW'($urandom);
        in_mant = 8'($urandom);
      end
    end
    in_valid = 1'b0;
    check("stream_sent", RW'(sent), RW'(20));
    drain();

    // Fill both stages, stall one cycle, then reset mid-stream
    out_ready = 1'b0;
    send(1'b0, EW'(12), 8'h33);
    send(1'b1, EW'(4), 8'h02);
    in_valid = 1'b1; in_sign = 1'b1; in_exp = EW'(20); in_mant = 8'h5A;
    tick();
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("mrst_valid", RW'(out_valid), RW'(0));
    check("mrst_in_ready", RW'(in_ready), RW'(1));
    out_ready = 1'b1;
    send(1'b0, EW'(10), 8'h10);
    check("lat2_s1", RW'(out_valid), RW'(0));
    tick();
    expect_now("after_rst", {1'b0, EW'(7), 8'h80, 1'b0, 1'b0});
    tick();
    check("no_stale", RW'(out_valid), RW'(0));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
